// File: rtl/pipe_reg_file.sv
// pipe_reg_file
//   Clocked register file for the pipelined processor. It has two combinational
//   read ports, one synchronous write port, optional write-to-read forwarding and
//   a per-register busy scoreboard. Decode uses the scoreboard to detect
//   read-after-write hazards against in-flight producers.
//
// Parameters
//   DATA_W   register width
//   ADDR_W   address width, NREGS = 2**ADDR_W
//   BYPASS   1 = same-cycle write data is forwarded to the read ports
//   ZERO_REG 1 = R0 reads as zero; writes and busy-set to R0 are ignored
//
// Ports
//   Clk                  clock; all state changes on the rising edge
//   Reset                synchronous active-low reset (R[i] = i, busy cleared)
//   Rd_Addr_A/B          read addresses
//   Rd_Data_A/B          combinational read data
//   Hazard_A/B           read source has a pending, unforwarded producer
//   Wr_En/Wr_Addr/Wr_Data  write port from EX/WB
//   Busy_Set/Busy_Addr   issue strobe that marks a destination as pending
module pipe_reg_file #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] Rd_Addr_A,
   input  logic [ADDR_W-1:0] Rd_Addr_B,
   output logic [DATA_W-1:0] Rd_Data_A,
   output logic [DATA_W-1:0] Rd_Data_B,
   output logic              Hazard_A,
   output logic              Hazard_B,
   input  logic              Wr_En,
   input  logic [ADDR_W-1:0] Wr_Addr,
   input  logic [DATA_W-1:0] Wr_Data,
   input  logic              Busy_Set,
   input  logic [ADDR_W-1:0] Busy_Addr
);

   localparam int unsigned NREGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NREGS];
   logic [NREGS-1:0]  busy;

   logic wr_ok;
   logic set_ok;
   logic fwd_a, fwd_b;
   logic zero_a, zero_b;

   // Writes and issues aimed at a hardwired R0 are dropped before they reach state.
   always_comb begin
      wr_ok  = Wr_En    && !((ZERO_REG != 0) && (Wr_Addr   == '0));
      set_ok = Busy_Set && !((ZERO_REG != 0) && (Busy_Addr == '0));
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i] <= DATA_W'(i);
         end
         busy <= '0;
      end else begin
         if (wr_ok) begin
            regs[Wr_Addr] <= Wr_Data;
         end
         // Set has priority over clear: the newly issued producer owns the register.
         for (int unsigned i = 0; i < NREGS; i++) begin
            if (set_ok && (Busy_Addr == ADDR_W'(i))) begin
               busy[i] <= 1'b1;
            end else if (Wr_En && (Wr_Addr == ADDR_W'(i))) begin
               busy[i] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      zero_a = (ZERO_REG != 0) && (Rd_Addr_A == '0);
      zero_b = (ZERO_REG != 0) && (Rd_Addr_B == '0);
      fwd_a  = (BYPASS != 0) && Wr_En && (Wr_Addr == Rd_Addr_A);
      fwd_b  = (BYPASS != 0) && Wr_En && (Wr_Addr == Rd_Addr_B);

      if (zero_a) begin
         Rd_Data_A = '0;
      end else if (fwd_a) begin
         Rd_Data_A = Wr_Data;
      end else begin
         Rd_Data_A = regs[Rd_Addr_A];
      end

      if (zero_b) begin
         Rd_Data_B = '0;
      end else if (fwd_b) begin
         Rd_Data_B = Wr_Data;
      end else begin
         Rd_Data_B = regs[Rd_Addr_B];
      end

      // A forwarded write satisfies the consumer in the same cycle, so it masks the busy bit.
      Hazard_A = !zero_a && busy[Rd_Addr_A] && !fwd_a;
      Hazard_B = !zero_b && busy[Rd_Addr_B] && !fwd_b;
   end

endmodule

// File: tb/tb_pipe_reg_file.sv
// Testbench for pipe_reg_file. Three instances share the stimulus:
//   dut0: BYPASS=0 ZERO_REG=0, dut1: BYPASS=1 ZERO_REG=0, dut2: BYPASS=1 ZERO_REG=1.
// A behavioural register/busy array model predicts every output.
module tb_pipe_reg_file;

   logic       clk;
   logic       reset;
   logic [2:0] rd_addr_a, rd_addr_b, wr_addr, busy_addr;
   logic       wr_en, busy_set;
   logic [7:0] wr_data;

   wire [2:0][7:0] rda, rdb;
   wire [2:0]      hza, hzb;

   int checks = 0;
   int errors = 0;

   // model state per configuration
   logic [7:0] m_mem  [3][8];
   bit         m_busy [3][8];

   pipe_reg_file #(.DATA_W(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) dut0 (
      .Clk(clk), .Reset(reset), .Rd_Addr_A(rd_addr_a), .Rd_Addr_B(rd_addr_b),
      .Rd_Data_A(rda[0]), .Rd_Data_B(rdb[0]), .Hazard_A(hza[0]), .Hazard_B(hzb[0]),
      .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
      .Busy_Set(busy_set), .Busy_Addr(busy_addr));

   pipe_reg_file #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) dut1 (
      .Clk(clk), .Reset(reset), .Rd_Addr_A(rd_addr_a), .Rd_Addr_B(rd_addr_b),
      .Rd_Data_A(rda[1]), .Rd_Data_B(rdb[1]), .Hazard_A(hza[1]), .Hazard_B(hzb[1]),
      .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
      .Busy_Set(busy_set), .Busy_Addr(busy_addr));

   pipe_reg_file #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) dut2 (
      .Clk(clk), .Reset(reset), .Rd_Addr_A(rd_addr_a), .Rd_Addr_B(rd_addr_b),
      .Rd_Data_A(rda[2]), .Rd_Data_B(rdb[2]), .Hazard_A(hza[2]), .Hazard_B(hzb[2]),
      .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
      .Busy_Set(busy_set), .Busy_Addr(busy_addr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit byp(input int c);
      return c != 0;
   endfunction

   function automatic bit zr(input int c);
      return c == 2;
   endfunction

   function automatic logic [7:0] exp_rd(input int c, input logic [2:0] a);
      if (zr(c) && a == 3'd0) return 8'h00;
      if (byp(c) && wr_en && wr_addr == a) return wr_data;
      return m_mem[c][a];
   endfunction

   function automatic bit exp_hz(input int c, input logic [2:0] a);
      if (zr(c) && a == 3'd0) return 1'b0;
      return m_busy[c][a] && !(byp(c) && wr_en && wr_addr == a);
   endfunction

   // one rising edge; the model consumes the inputs present at that edge
   task automatic edge_step();
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         if (!reset) begin
            for (int i = 0; i < 8; i++) begin
               m_mem[c][i]  = 8'(i);
               m_busy[c][i] = 1'b0;
            end
         end else begin
            if (wr_en && !(zr(c) && wr_addr == 3'd0)) m_mem[c][wr_addr] = wr_data;
            if (wr_en) m_busy[c][wr_addr] = 1'b0;
            if (busy_set && !(zr(c) && busy_addr == 3'd0)) m_busy[c][busy_addr] = 1'b1;
         end
      end
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; busy_set = 1'b0; reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; wr_en = 1'b0; busy_set = 1'b0;
      wr_addr = '0; wr_data = '0; busy_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
      edge_step();
      reset = 1'b1;
      for (int a = 0; a < 8; a++) begin
         rd_addr_a = 3'(a);
         rd_addr_b = 3'(7 - a);
         #1;
         for (int c = 0; c < 3; c++) begin
            checks++;
            if (rda[c] !== 8'(a)) begin
               errors++; $display("FAIL reset_rd_a dut%0d addr %0d: got %h want %h", c, a, rda[c], 8'(a));
            end
            checks++;
            if (rdb[c] !== 8'(7 - a)) begin
               errors++; $display("FAIL reset_rd_b dut%0d addr %0d: got %h want %h", c, 7 - a, rdb[c], 8'(7 - a));
            end
            checks++;
            if (hza[c] !== 1'b0 || hzb[c] !== 1'b0) begin
               errors++; $display("FAIL reset_hazard dut%0d: got %b%b want 00", c, hza[c], hzb[c]);
            end
         end
      end
   endtask

   task automatic test_write_read();
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; rd_addr_a = 3'd3;
      #1;
      checks++;
      if (rda[0] !== 8'h03) begin
         errors++; $display("FAIL wr_same_cycle_nobypass: got %h want 03", rda[0]);
      end
      checks++;
      if (rda[1] !== 8'hA5) begin
         errors++; $display("FAIL wr_same_cycle_bypass: got %h want a5", rda[1]);
      end
      edge_step();
      idle();
      #1;
      checks++;
      if (rda[0] !== 8'hA5) begin
         errors++; $display("FAIL wr_next_cycle_nobypass: got %h want a5", rda[0]);
      end
   endtask

   task automatic test_scoreboard();
      busy_set = 1'b1; busy_addr = 3'd5;
      edge_step();
      idle();
      edge_step();
      rd_addr_a = 3'd5;
      #1;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (hza[c] !== 1'b1) begin
            errors++; $display("FAIL sb_busy dut%0d: got %b want 1", c, hza[c]);
         end
      end
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
      #1;
      checks++;
      if (hza[1] !== 1'b0 || rda[1] !== 8'h3C) begin
         errors++; $display("FAIL sb_bypass_clear: got hz=%b rd=%h want hz=0 rd=3c", hza[1], rda[1]);
      end
      checks++;
      if (hza[0] !== 1'b1 || rda[0] !== 8'h05) begin
         errors++; $display("FAIL sb_nobypass_wrcycle: got hz=%b rd=%h want hz=1 rd=05", hza[0], rda[0]);
      end
      edge_step();
      idle();
      #1;
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (hza[c] !== 1'b0 || rda[c] !== 8'h3C) begin
            errors++; $display("FAIL sb_after_write dut%0d: got hz=%b rd=%h want hz=0 rd=3c", c, hza[c], rda[c]);
         end
      end
   endtask

   task automatic test_set_clear();
      busy_set = 1'b1; busy_addr = 3'd2;
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h11;
      edge_step();
      idle();
      rd_addr_b = 3'd2;
      #1;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (rdb[c] !== 8'h11 || hzb[c] !== 1'b1) begin
            errors++; $display("FAIL set_wins dut%0d: got rd=%h hz=%b want rd=11 hz=1", c, rdb[c], hzb[c]);
         end
      end
   endtask

   task automatic test_zero_reg();
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
      busy_set = 1'b1; busy_addr = 3'd0; rd_addr_a = 3'd0;
      #1;
      checks++;
      if (rda[2] !== 8'h00 || hza[2] !== 1'b0) begin
         errors++; $display("FAIL zero_same_cycle: got rd=%h hz=%b want rd=00 hz=0", rda[2], hza[2]);
      end
      edge_step();
      idle();
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (rda[2] !== 8'h00 || hza[2] !== 1'b0) begin
            errors++; $display("FAIL zero_after_%0d: got rd=%h hz=%b want rd=00 hz=0", k, rda[2], hza[2]);
         end
         checks++;
         if (rda[0] !== 8'hFF || hza[0] !== 1'b1) begin
            errors++; $display("FAIL r0_normal_%0d: got rd=%h hz=%b want rd=ff hz=1", k, rda[0], hza[0]);
         end
         edge_step();
      end
   endtask

   task automatic test_reset_mid();
      busy_set = 1'b1; busy_addr = 3'd1;
      edge_step();
      busy_addr = 3'd4;
      edge_step();
      busy_set = 1'b0;
      reset = 1'b0; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h77;
      edge_step();
      idle();
      rd_addr_a = 3'd4; rd_addr_b = 3'd1;
      #1;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (rda[c] !== 8'h04 || rdb[c] !== 8'h01) begin
            errors++; $display("FAIL reset_mid_data dut%0d: got %h/%h want 04/01", c, rda[c], rdb[c]);
         end
         checks++;
         if (hza[c] !== 1'b0 || hzb[c] !== 1'b0) begin
            errors++; $display("FAIL reset_mid_busy dut%0d: got %b%b want 00", c, hza[c], hzb[c]);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         reset     = ($urandom_range(0, 31) != 0);
         wr_en     = 1'($urandom_range(0, 1));
         busy_set  = ($urandom_range(0, 2) == 0);
         wr_addr   = 3'($urandom);
         busy_addr = 3'($urandom);
         wr_data   = 8'($urandom);
         rd_addr_a = 3'($urandom);
         rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : 3'($urandom);
         #1;
         for (int c = 0; c < 3; c++) begin
            checks++;
            if (rda[c] !== exp_rd(c, rd_addr_a) || rdb[c] !== exp_rd(c, rd_addr_b)) begin
               errors++;
               $display("FAIL rand_rd dut%0d cyc %0d: got %h/%h want %h/%h", c, n,
                        rda[c], rdb[c], exp_rd(c, rd_addr_a), exp_rd(c, rd_addr_b));
            end
            checks++;
            if (hza[c] !== exp_hz(c, rd_addr_a) || hzb[c] !== exp_hz(c, rd_addr_b)) begin
               errors++;
               $display("FAIL rand_hz dut%0d cyc %0d: got %b%b want %b%b", c, n,
                        hza[c], hzb[c], exp_hz(c, rd_addr_a), exp_hz(c, rd_addr_b));
            end
         end
         edge_step();
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_scoreboard();
      test_set_clear();
      test_zero_reg();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_reg_file.md
# pipe_reg_file

Parametrised, clocked register file for the pipelined processor, replacing the level-sensitive single-read-port register block. It provides two combinational read ports, one synchronous write port, optional write-to-read bypass and a per-register busy scoreboard. The scoreboard lets the decode stage detect read-after-write hazards against in-flight producers. It sits in ID, is written from the EX/WB stage, and keeps the existing index-value reset image (R[i] = i).

## Interface
- DATA_W, 8: register width in bits.
- ADDR_W, 3: address width; NREGS = 2**ADDR_W registers.
- BYPASS, 1: 1 = same-cycle write data forwarded to read ports; 0 = no forwarding.
- ZERO_REG, 0: 1 = R0 hardwired to zero, writes and busy-set to R0 ignored.

- Clk  in  1  single clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-low reset, sampled on rising Clk.
- Rd_Addr_A  in  ADDR_W  read port A address.
- Rd_Addr_B  in  ADDR_W  read port B address.
- Rd_Data_A  out  DATA_W  read port A data, combinational.
- Rd_Data_B  out  DATA_W  read port B data, combinational.
- Hazard_A  out  1  port A source has a pending, unforwarded producer.
- Hazard_B  out  1  port B source has a pending, unforwarded producer.
- Wr_En  in  1  write strobe from EX/WB.
- Wr_Addr  in  ADDR_W  write destination.
- Wr_Data  in  DATA_W  write data.
- Busy_Set  in  1  issue strobe; marks Busy_Addr as having a pending write.
- Busy_Addr  in  ADDR_W  destination of the issued instruction.

## Operation
- Storage: NREGS x DATA_W flops plus NREGS busy bits.
- Reset (Reset==0 at rising Clk): R[i] = i truncated to DATA_W; all busy bits cleared; R0 = 0 when ZERO_REG=1 (same value). Reset overrides Wr_En and Busy_Set in the same cycle.
- Write: when Wr_En=1 and Reset=1, R[Wr_Addr] <= Wr_Data at the rising edge. Ignored for Wr_Addr=0 when ZERO_REG=1.
- Read: Rd_Data_X = R[Rd_Addr_X], with two overrides:
  - ZERO_REG=1 and Rd_Addr_X=0: output is 0.
  - Otherwise, BYPASS=1, Wr_En=1 and Wr_Addr==Rd_Addr_X: output is Wr_Data.
- Both ports are independent; reading the same address on both ports is legal and returns the same value.
- Scoreboard per register i, at rising Clk with Reset=1:
  - Busy_Set=1 and Busy_Addr==i sets busy[i].
  - Otherwise, Wr_En=1 and Wr_Addr==i clears busy[i].
  - Simultaneous set and clear of the same i: set wins, because the newer producer owns the register.
  - Busy is never set for R0 when ZERO_REG=1.
- Hazard_X = busy[Rd_Addr_X] AND NOT (BYPASS=1 AND Wr_En=1 AND Wr_Addr==Rd_Addr_X). Hazard_X is forced to 0 for R0 when ZERO_REG=1.
- One write port, so there are no write-write conflicts. Single in-order issue: at most one pending producer per register.

## Timing
- Read latency: 0 cycles, combinational from address and state.
- Write visibility: BYPASS=1 gives same cycle, via forwarding; BYPASS=0 gives the cycle after the write edge.
- Busy visibility: Hazard rises the cycle after the Busy_Set edge. It falls in the write cycle with BYPASS=1, or the cycle after the write edge with BYPASS=0.
- Reset: outputs reflect the reset image from the cycle after the first rising edge with Reset=0. Before the first reset, contents are undefined.
- Reset asserted mid-operation discards the pending write and all busy bits in that cycle. No partial update occurs.
- No outputs are registered. Hazard_X feeds the stall logic combinationally.

## Test plan
- Reset: hold Reset=0 for 1 edge, then read all addresses on A and B -> Rd_Data = 0..7, Hazard_A = Hazard_B = 0.
- Write then read, BYPASS=0: write R3=8'hA5 -> the same-cycle read of R3 returns 8'h03, the next cycle returns 8'hA5. With BYPASS=1 -> 8'hA5 in the same cycle.
- Scoreboard: Busy_Set on R5, wait 2 cycles -> Hazard_A=1 on Rd_Addr_A=5. Write R5=8'h3C with BYPASS=1 -> the same cycle gives Hazard_A=0 and Rd_Data_A=8'h3C, and busy[5] is clear afterwards.
- Simultaneous set/clear: Busy_Set on R2 with Wr_En to R2 (8'h11) in the same edge -> R2=8'h11, busy[2]=1, Hazard_B=1 on the next cycle.
- ZERO_REG=1: write R0=8'hFF and Busy_Set R0 -> Rd_Data_A=0, Hazard_A=0 on all following cycles.
- Reset mid-operation: busy R1, R4 set, then Reset=0 with Wr_En to R4=8'h77 in the same edge -> R4=8'h04, all busy bits 0.
